// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared states and constants for the boot-stream loader (CHK exists only with LOADER_CHECKSUM_EN)
package program_loader_pkg;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 256;
    localparam int NW             = 8 * HDR_BYTES;
    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;
endpackage

// File: rtl/program_loader_packer.sv
// byte_to_word_packer: assembles MSB-first bytes into 32-bit words, flags the completing byte
module byte_to_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data_in,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam int CW = $clog2(BYTES_PER_WORD);
    logic [8*(BYTES_PER_WORD-1)-1:0] shreg;
    logic [CW-1:0] cnt;
    assign word       = {shreg, data_in};
    assign word_valid = load && cnt == CW'(BYTES_PER_WORD - 1);
    // shift accepted bytes in; counter wraps after the last byte of a word
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= word[8*(BYTES_PER_WORD-1)-1:0];
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: parses a length-prefixed boot stream into instruction-memory writes; LOADER_CHECKSUM_EN adds a trailing XOR check byte
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);
    localparam int IW = $clog2(DEPTH) + 1;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER = CHK;
    logic [7:0] csum;
`else
    localparam state_t AFTER = DONE;
`endif
    state_t state, next;
    logic [NW-1:0] n;
    logic [IW-1:0] widx;
    logic [31:0] word;
    logic word_valid;
    logic xfer, load, last, rearm;
    logic [NW-1:0] count;

    assign in_ready = state != DONE && state != ERROR;
    assign xfer     = in_valid && in_ready;
    assign load     = xfer && state == DATA;
    assign count    = {n[NW-1:8], in_byte};
    assign last     = 32'(widx) + 1 == 32'(n);
    assign rearm    = restart && !in_ready;
    assign done     = state == DONE;
    assign error    = state == ERROR;
    assign cpu_rst  = state != DONE;

    byte_to_word_packer packer (
        .clk(clk),
        .rst(rst),
        .clear(rearm),
        .load(load),
        .data_in(in_byte),
        .word(word),
        .word_valid(word_valid)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= HDR_HI;
        else     state <= next;
    end

    // next-state decode: header length check, last word, checksum compare, re-arm
    always_comb begin
        next = state;
        case (state)
            HDR_HI: if (xfer) next = HDR_LO;
            HDR_LO: if (xfer) next = count == '0 ? AFTER : (32'(count) > DEPTH ? ERROR : DATA);
            DATA:   if (word_valid && last) next = AFTER;
`ifdef LOADER_CHECKSUM_EN
            CHK:    if (xfer) next = in_byte == csum ? DONE : ERROR;
`endif
            DONE:   if (restart) next = HDR_HI;
            ERROR:  if (restart) next = HDR_HI;
            default: next = HDR_HI;
        endcase
    end

    // header capture, word addressing, write port and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            n            <= '0;
            widx         <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= BASE_ADDR;
            imem_wr_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            imem_wr_en <= word_valid;
            if (word_valid) begin
                imem_wr_data <= word;
                imem_wr_addr <= BASE_ADDR + (32'(widx) << 2);
                widx         <= widx + 1'b1;
            end
            if (xfer && state == HDR_HI) n <= NW'({in_byte, 8'h00});
            if (xfer && state == HDR_LO) n <= count;
`ifdef LOADER_CHECKSUM_EN
            if (load) csum <= csum ^ in_byte;
            if (rearm) csum <= '0;
`endif
            if (rearm) begin
                n    <= '0;
                widx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and hand-written image loads checked against a stream-level model
module tb_program_loader;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk, rst, in_valid, in_ready, restart;
    logic [7:0]  in_byte;
    logic        imem_wr_en, cpu_rst, done, error;
    logic [31:0] imem_wr_addr, imem_wr_data;

    program_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .restart(restart), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data), .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
    typedef struct {int n; int gap; logic [7:0] delta; bit rs; bit exp_done; bit exp_err;} vec_t;

    wr_t got[$];
    logic [31:0] words[$];
    int checks = 0, failures = 0;

    always @(negedge clk) if (imem_wr_en) got.push_back({imem_wr_addr, imem_wr_data});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        in_valid = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1;
        in_byte  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
        @(negedge clk);
        in_valid = 0;
        in_byte  = $urandom;
    endtask

    task automatic set_random(input int n);
        words.delete();
        for (int k = 0; k < n && n <= DEPTH; k++) words.push_back($urandom);
    endtask

    task automatic do_restart();
        restart = 1;
        @(negedge clk);
        restart = 0;
        check("restart_ready", in_ready, 1);
        check("restart_done", done, 0);
        check("restart_error", error, 0);
    endtask

    // Model: build the byte stream and the expected write list straight from the stream format.
    task automatic run_image(input int n, input int gap, input logic [7:0] delta, input bit rs,
                             input bit exp_done, input bit exp_err);
        logic [7:0] s[$];
        wr_t exp[$];
        logic [7:0] x = 0;
        logic [15:0] h = 16'(n);
        got.delete();
        s.push_back(h[15:8]);
        s.push_back(h[7:0]);
        if (n <= DEPTH) begin
            for (int k = 0; k < n; k++) begin
                logic [31:0] w = words[k];
                for (int j = 3; j >= 0; j--) begin
                    s.push_back(w[8*j +: 8]);
                    x ^= w[8*j +: 8];
                end
                exp.push_back({BASE + 32'(4 * k), w});
            end
`ifdef LOADER_CHECKSUM_EN
            s.push_back(x ^ delta);
`endif
        end
        for (int i = 0; i < s.size(); i++) begin
            if (rs && i == 2) begin
                restart = 1;
                @(negedge clk);
                restart = 0;
            end
            send_byte(s[i], gap == 0 ? 0 : $urandom_range(gap));
        end
        repeat (2) @(negedge clk);
        check($sformatf("n%0d_wr_count", n), got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            check($sformatf("n%0d_write%0d", n, k), got[k], exp[k]);
        check($sformatf("n%0d_done", n), done, exp_done);
        check($sformatf("n%0d_error", n), error, exp_err);
        check($sformatf("n%0d_cpu_rst", n), cpu_rst, !exp_done);
        check($sformatf("n%0d_in_ready", n), in_ready, 0);
        if (exp.size() > 0) check($sformatf("n%0d_hold", n), {imem_wr_addr, imem_wr_data}, exp[exp.size()-1]);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{n: 1,        gap: 0, delta: 8'h00, rs: 0, exp_done: 1, exp_err: 0};
        tbl[1] = '{n: 5,        gap: 5, delta: 8'h00, rs: 1, exp_done: 1, exp_err: 0};
        tbl[2] = '{n: 0,        gap: 2, delta: 8'h00, rs: 0, exp_done: 1, exp_err: 0};
        tbl[3] = '{n: DEPTH,    gap: 0, delta: 8'h00, rs: 0, exp_done: 1, exp_err: 0};
        tbl[4] = '{n: DEPTH+1,  gap: 0, delta: 8'h00, rs: 0, exp_done: 0, exp_err: 1};
        tbl[5] = '{n: 16'hFFFF, gap: 3, delta: 8'h00, rs: 0, exp_done: 0, exp_err: 1};
`ifdef LOADER_CHECKSUM_EN
        tbl[6] = '{n: 4,        gap: 3, delta: 8'h01, rs: 0, exp_done: 0, exp_err: 1};
`else
        tbl[6] = '{n: 4,        gap: 3, delta: 8'h01, rs: 0, exp_done: 1, exp_err: 0};
`endif
        rst = 1; in_valid = 0; in_byte = 0; restart = 0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", imem_wr_en, 0);
        check("rst_addr", imem_wr_addr, BASE);
        check("rst_data", imem_wr_data, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_ready", in_ready, 1);
        rst = 0;

        words.delete();
        words.push_back(32'h2001_0005);
        words.push_back(32'h8C22_0004);
        run_image(2, 0, 8'h00, 0, 1, 0);
        do_restart();

        run_image(16'h0101, 0, 8'h00, 0, 0, 1);
        do_restart();

        for (int i = 0; i < 7; i++) begin
            set_random(tbl[i].n);
            run_image(tbl[i].n, tbl[i].gap, tbl[i].delta, tbl[i].rs, tbl[i].exp_done, tbl[i].exp_err);
            do_restart();
        end

        // back-to-back versus gapped load of the same image must write identically
        set_random(6);
        run_image(6, 0, 8'h00, 0, 1, 0);
        do_restart();
        run_image(6, 5, 8'h00, 0, 1, 0);
        do_restart();

`ifdef LOADER_CHECKSUM_EN
        words.delete();
        words.push_back(32'h1122_3344);
        run_image(1, 0, 8'h00, 0, 1, 0);
        do_restart();
        run_image(1, 0, 8'h01, 0, 0, 1);
        do_restart();
`endif

        // reset mid-image: partial word discarded, fresh image lands at BASE
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_ready", in_ready, 1);
        check("midrst_addr", imem_wr_addr, BASE);
        check("midrst_data", imem_wr_data, 0);
        check("midrst_cpu_rst", cpu_rst, 1);
        set_random(1);
        run_image(1, 2, 8'h00, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
